// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch queue, instruction
// memory, the EX redirect source and the ID stage.
//   redirect_valid/redirect_pc       : flush and restart fetch at a new PC
//   imem_req_valid/ready, imem_addr  : request channel to instruction memory
//   imem_rsp_valid/data              : in-order response channel
//   inst_valid/ready, inst_data/pc   : FIFO head towards IF/ID
// master = fetch_queue side, slave = environment side.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Issues sequential PCs to
// instruction memory with up to MAX_OUTST requests in flight, buffers the
// returned words with their PCs in a DEPTH-entry FIFO, and on a redirect
// flushes the FIFO and drops every response still in flight.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_queue_if.master (redirect, imem request/response, inst head)
module fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0]            fetch_pc;
  logic [CW-1:0]              count, outst, discard;
  logic [PW-1:0]              rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [DEPTH-1:0][XLEN-1:0] inst_mem, pc_mem, tag_mem;

  logic          redirect, rsp, accept, pop, wr, req_ok;
  logic [CW:0]   credit_used;
  logic          unused_pc_lsb;

  assign redirect = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;

  // Slots already promised: buffered entries plus live (non-stale) requests.
  assign credit_used = {1'b0, count} + {1'b0, outst} - {1'b0, discard};

  // rst_n gating keeps the request low while reset is held; everything else
  // is registered state, so a pop only frees credit on the next cycle.
  assign req_ok = rst_n && !redirect
               && (outst < CW'(MAX_OUTST))
               && (credit_used < (CW+1)'(DEPTH));
  assign accept = req_ok && bus.imem_req_ready;

  // A redirect flushes the head, so a same-cycle pop is meaningless.
  assign pop = (count != '0) && bus.inst_ready && !redirect;

  // Live responses are written unless the FIFO is full and nothing leaves;
  // that case cannot happen by credit and is flagged below.
  assign wr = rsp && !redirect && (discard == '0)
           && ((count != CW'(DEPTH)) || pop);

  assign bus.imem_req_valid = req_ok;
  assign bus.imem_addr      = fetch_pc;
  assign bus.inst_valid     = (count != '0);
  assign bus.inst_data      = inst_mem[rd_ptr];
  assign bus.inst_pc        = pc_mem[rd_ptr];

  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      inst_mem <= '0;
      pc_mem   <= '0;
      tag_mem  <= '0;
    end else begin
      // PC tags follow the request stream in order; redirects leave them
      // alone because stale responses still consume their tag.
      if (accept) begin
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= tag_wr + PW'(1);
      end
      if (rsp) tag_rd <= tag_rd + PW'(1);
      outst <= outst + CW'(accept) - CW'(rsp);

      if (redirect) begin
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        // Everything still in flight after this cycle's response is stale.
        discard  <= outst - CW'(rsp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
        if (wr) begin
          inst_mem[wr_ptr] <= bus.imem_rsp_data;
          pc_mem[wr_ptr]   <= tag_mem[tag_rd];
          wr_ptr           <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp && !redirect && (discard == '0) && (count == CW'(DEPTH)) && !pop))
    else $error("fetch_queue: live response with full FIFO");

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int XLEN      = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN)) fq ();
  fetch_queue_if #(.XLEN(XLEN)) fw ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST),
                .RESET_PC(32'h0000_0000))
    dut (.clk(clk), .rst_n(rst_n), .bus(fq));

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST),
                .RESET_PC(32'hFFFF_FFF8))
    dut_w (.clk(clk), .rst_n(rst_n), .bus(fw));

  int          n_chk = 0, n_pass = 0;
  int          lat = 1, ncyc = 0, bad_data = 0;
  logic [31:0] mq_addr[$];
  int          mq_rdy[$];
  logic [31:0] pop_pc[$];
  int          pop_cyc[$];
  logic [31:0] popw_pc[$];
  logic [31:0] last_acc = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_DEAD;
  endfunction

  // One clock: sample the handshakes ahead of the rising edge, then at the
  // falling edge advance the memory models (in-order, fixed latency).
  task automatic step();
    logic acc, accw;
    logic [31:0] a, aw;
    #1;
    acc  = fq.imem_req_valid && fq.imem_req_ready;
    a    = fq.imem_addr;
    accw = fw.imem_req_valid && fw.imem_req_ready;
    aw   = fw.imem_addr;
    if (acc) last_acc = a;
    if (fq.inst_valid && fq.inst_ready && !fq.redirect_valid) begin
      pop_pc.push_back(fq.inst_pc);
      pop_cyc.push_back(ncyc);
      if (fq.inst_data !== mem_f(fq.inst_pc)) bad_data++;
    end
    if (fw.inst_valid && fw.inst_ready) popw_pc.push_back(fw.inst_pc);
    @(negedge clk);
    ncyc++;
    if (acc) begin
      mq_addr.push_back(a);
      mq_rdy.push_back(ncyc + lat - 1);
    end
    if (mq_addr.size() > 0 && mq_rdy[0] <= ncyc) begin
      fq.imem_rsp_valid = 1'b1;
      fq.imem_rsp_data  = mem_f(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end else begin
      fq.imem_rsp_valid = 1'b0;
      fq.imem_rsp_data  = '0;
    end
    fw.imem_rsp_valid = accw;
    fw.imem_rsp_data  = accw ? mem_f(aw) : '0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = pc;
    step();
    fq.redirect_valid = 1'b0;
  endtask

  // Count log entries that break the +4 sequence starting at base.
  function automatic int nonseq(input logic [31:0] base);
    int n = 0;
    for (int i = 0; i < pop_pc.size(); i++)
      if (pop_pc[i] !== base + 32'(4 * i)) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   gaps, exp_disc;
    bit   found;
    logic [31:0] exp_addr;

    fq.redirect_valid = 0; fq.redirect_pc = '0; fq.imem_req_ready = 1;
    fq.imem_rsp_valid = 0; fq.imem_rsp_data = '0; fq.inst_ready = 1;
    fw.redirect_valid = 0; fw.redirect_pc = '0; fw.imem_req_ready = 1;
    fw.imem_rsp_valid = 0; fw.imem_rsp_data = '0; fw.inst_ready = 1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(fq.imem_req_valid), 32'd0);
    chk("rst_addr",      fq.imem_addr, 32'h0);
    chk("rst_inst_valid",32'(fq.inst_valid), 32'd0);
    chk("rst_inst_data", fq.inst_data, 32'h0);
    chk("rst_inst_pc",   fq.inst_pc, 32'h0);
    chk("rst_count",     32'(dut.count), 32'd0);
    chk("rst_outst",     32'(dut.outst), 32'd0);
    chk("rst_discard",   32'(dut.discard), 32'd0);
    chk("rst_addr_w",    fw.imem_addr, 32'hFFFF_FFF8);
    step(); step();

    // Reset release: streaming at one instruction per cycle.
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", 32'(fq.imem_req_valid), 32'd1);
    chk("first_req_addr",  fq.imem_addr, 32'h0);
    pop_pc.delete(); pop_cyc.delete(); popw_pc.delete();
    step(); step();
    chk("first_inst_valid", 32'(fq.inst_valid), 32'd1);
    chk("first_inst_pc",    fq.inst_pc, 32'h0);
    chk("first_inst_data",  fq.inst_data, mem_f(32'h0));
    repeat (10) step();
    for (int i = 0; i < 8; i++) chk($sformatf("stream_pc%0d", i), pop_at(i), 32'(4 * i));
    gaps = 0;
    for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
      if (pop_cyc[i] - pop_cyc[i-1] != 1) gaps++;
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("wrap_pc0", (popw_pc.size() > 0) ? popw_pc[0] : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
    chk("wrap_pc1", (popw_pc.size() > 1) ? popw_pc[1] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
    chk("wrap_pc2", (popw_pc.size() > 2) ? popw_pc[2] : 32'hDEAD_DEAD, 32'h0000_0000);

    // ID stall: FIFO fills to DEPTH, requests stop, then drains in order.
    fq.inst_ready = 1'b0;
    redirect_to(32'h0);
    repeat (20) step();
    #1;
    chk("stall_count",     32'(dut.count), 32'd4);
    chk("stall_req_valid", 32'(fq.imem_req_valid), 32'd0);
    chk("stall_outst",     32'(dut.outst), 32'd0);
    chk("stall_head_pc",   fq.inst_pc, 32'h0);
    pop_pc.delete(); pop_cyc.delete();
    fq.inst_ready = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 6; i++) chk($sformatf("drain_pc%0d", i), pop_at(i), 32'(4 * i));

    // Redirect with two requests outstanding on a slow memory.
    lat = 3;
    for (int i = 0; i < 20 && dut.outst != 2; i++) step();
    chk("redir_outst2", 32'(dut.outst), 32'd2);
    exp_disc = 2 - int'(fq.imem_rsp_valid);
    redirect_to(32'h100);
    chk("redir_inst_valid", 32'(fq.inst_valid), 32'd0);
    chk("redir_discard",    32'(dut.discard), 32'(exp_disc));
    pop_pc.delete(); pop_cyc.delete();
    repeat (20) step();
    chk("redir_first_pc", pop_at(0), 32'h100);
    chk("redir_seq",      32'(nonseq(32'h100)), 32'd0);

    // Memory back-pressure: address holds, then a redirect withdraws it.
    lat = 1;
    fq.imem_req_ready = 1'b0;
    repeat (4) step();
    #1;
    exp_addr = last_acc + 32'd4;
    chk("bp_req_valid", 32'(fq.imem_req_valid), 32'd1);
    chk("bp_outst0",    32'(dut.outst), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_addr%0d", i), fq.imem_addr, exp_addr);
    end
    chk("bp_outst_end", 32'(dut.outst), 32'd0);
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = 32'h202;
    #1;
    chk("bp_withdraw", 32'(fq.imem_req_valid), 32'd0);
    step();
    fq.redirect_valid = 1'b0;
    last_acc = 32'hFFFF_FFFF;
    #1;
    chk("bp_redir_addr", fq.imem_addr, 32'h200);
    fq.imem_req_ready = 1'b1;
    step();
    chk("bp_next_accept", last_acc, 32'h200);

    // Redirect coinciding with a response and a pop while the FIFO is busy.
    lat = 3;
    fq.inst_ready = 1'b0;
    redirect_to(32'h280);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (dut.count == 2 && dut.outst == 2 && dut.discard == 0 && fq.imem_rsp_valid) found = 1;
      else step();
    end
    chk("busy_reached", 32'(found), 32'd1);
    fq.inst_ready = 1'b1;
    redirect_to(32'h300);
    chk("busy_inst_valid", 32'(fq.inst_valid), 32'd0);
    chk("busy_discard",    32'(dut.discard), 32'd1);
    chk("busy_count",      32'(dut.count), 32'd0);
    pop_pc.delete(); pop_cyc.delete();
    repeat (25) step();
    chk("busy_first_pc", pop_at(0), 32'h300);
    chk("busy_seq",      32'(nonseq(32'h300)), 32'd0);
    chk("data_match",    32'(bad_data), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
